// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU operation sequencer: ALU commands and FSM states.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    CMD_ADD  = 3'b000,
    CMD_SUB  = 3'b001,
    CMD_XOR  = 3'b010,
    CMD_SLT  = 3'b011,
    CMD_AND  = 3'b100,
    CMD_NAND = 3'b101,
    CMD_NOR  = 3'b110,
    CMD_OR   = 3'b111
  } alu_cmd_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } seq_state_e;

endpackage

// File: rtl/stability_tracker.sv
// Watches the ALU output word and reports when it has held still long enough,
// or when the settle window has run out.
module stability_tracker #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_WAIT      = 64,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             active,
  input  logic [WIDTH+2:0] sample,
  output logic             stable_done,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(MAX_WAIT - 1);

  logic [WIDTH+2:0] prev;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] wait_cnt;
  logic             first;
  logic             same;

  // The first settle cycle only seeds prev, so no comparison is trusted there.
  assign same        = (sample == prev);
  assign stable_done = active && !first && same && (stable_cnt == STABLE_LAST);
  assign timeout     = active && !stable_done && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_cnt <= '0;
      wait_cnt   <= '0;
      first      <= 1'b0;
    end else if (clear) begin
      stable_cnt <= '0;
      wait_cnt   <= '0;
      first      <= 1'b1;
    end else if (active) begin
      first <= 1'b0;
      if (first || !same)
        stable_cnt <= '0;
      else if (stable_cnt != STABLE_LAST)
        stable_cnt <= stable_cnt + 1'b1;
      if (wait_cnt != WAIT_LAST)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (active)
      prev <= sample;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Handshake front end for a combinational ALU: holds operands, waits for the outputs
// to settle, returns result and flags. Define ALU_CHECK_EN to add expected-result checking.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_WAIT      = 64,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_cmd,
`ifdef ALU_CHECK_EN
  input  logic [WIDTH-1:0] req_expect,
`endif
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_cmd,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carryout,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_timeout,
  output logic             rsp_mismatch
);

  seq_state_e       state;
  seq_state_e       state_next;
  logic             accept;
  logic             in_settle;
  logic             stable_done;
  logic             timeout;
  logic             capture;
  logic [WIDTH+2:0] sample;

  assign sample    = {alu_result, alu_carryout, alu_zero, alu_overflow};
  assign accept    = req_valid && req_ready;
  assign in_settle = (state == SETTLE);
  assign capture   = stable_done || timeout;

  stability_tracker #(
    .WIDTH        (WIDTH),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .MAX_WAIT     (MAX_WAIT),
    .CNT_W        (CNT_W)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept),
    .active     (in_settle),
    .sample     (sample),
    .stable_done(stable_done),
    .timeout    (timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = SETTLE;
      SETTLE:  if (capture)   state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs depend on state alone so reset clears them without a clock.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_cmd <= '0;
    end else if (accept) begin
      alu_a   <= req_a;
      alu_b   <= req_b;
      alu_cmd <= req_cmd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_result   <= '0;
      rsp_carryout <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else if (capture) begin
      rsp_result   <= alu_result;
      rsp_carryout <= alu_carryout;
      rsp_zero     <= alu_zero;
      rsp_overflow <= alu_overflow;
      rsp_timeout  <= timeout;
    end
  end

`ifdef ALU_CHECK_EN
  logic [WIDTH-1:0] expect_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      expect_q     <= '0;
      rsp_mismatch <= 1'b0;
    end else begin
      if (accept)
        expect_q <= req_expect;
      if (capture)
        rsp_mismatch <= timeout || (alu_result != expect_q);
    end
  end
`else
  assign rsp_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: drives a behavioural ALU (delayed, glitching or
// toggling) and checks every cycle against a settle-window model of the sequencer.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int SETTLE_CYCLES = 4;
  localparam int MAX_WAIT      = 64;
  localparam int M_DELAY  = 0;
  localparam int M_GLITCH = 1;
  localparam int M_TOGGLE = 2;
  localparam int P_IDLE   = 0;
  localparam int P_SETTLE = 1;
  localparam int P_RESP   = 2;
`ifdef ALU_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [2:0]  req_cmd = '0;
  logic [31:0] req_expect = '0;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_cmd;
  logic [31:0] alu_result;
  logic        alu_carryout, alu_zero, alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic        rsp_carryout, rsp_zero, rsp_overflow, rsp_timeout, rsp_mismatch;

  int n_checks = 0;
  int n_fail   = 0;
  int mode     = M_DELAY;

  alu_op_sequencer #(
    .WIDTH(32), .SETTLE_CYCLES(SETTLE_CYCLES), .MAX_WAIT(MAX_WAIT), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd),
`ifdef ALU_CHECK_EN
    .req_expect(req_expect),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
    .alu_result(alu_result), .alu_carryout(alu_carryout),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carryout(rsp_carryout),
    .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
    .rsp_timeout(rsp_timeout), .rsp_mismatch(rsp_mismatch)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference ALU returning {result, carryout, zero, overflow}.
  function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] cmd);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (cmd)
      CMD_ADD: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0]; c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      CMD_SUB: begin
        w = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = w[31:0]; c = w[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      CMD_XOR:  r = a ^ b;
      CMD_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      CMD_AND:  r = a & b;
      CMD_NAND: r = ~(a & b);
      CMD_NOR:  r = ~(a | b);
      default:  r = a | b;
    endcase
    return {r, c, (r == 32'd0), v};
  endfunction

  logic [34:0] d1 = '0;
  logic [34:0] d2 = '0;
  logic [34:0] alu_s;
  logic        tog = 1'b0;
  int          glitch_cnt = 0;

  always @(posedge clk) begin
    d1  <= alu_fn(alu_a, alu_b, alu_cmd);
    d2  <= d1;
    tog <= ~tog;
    if (mode == M_GLITCH && req_valid && req_ready) glitch_cnt <= 3;
    else if (glitch_cnt != 0)                       glitch_cnt <= glitch_cnt - 1;
  end

  always_comb begin
    alu_s = alu_fn(alu_a, alu_b, alu_cmd);
    if (mode == M_DELAY)
      alu_s = d2;
    else if (mode == M_GLITCH && glitch_cnt != 0)
      alu_s = {32'hA5A5_0000 | 32'(glitch_cnt), 3'b000};
    else if (mode == M_TOGGLE)
      alu_s = alu_s ^ {31'b0, tog, 3'b000};
  end

  assign {alu_result, alu_carryout, alu_zero, alu_overflow} = alu_s;

  // Model: respond once SETTLE_CYCLES+1 consecutive settle samples agree, or after MAX_WAIT samples.
  initial begin : model
    int          ph;
    int          k;
    logic [31:0] ea, eb, ee;
    logic [2:0]  ec;
    logic [34:0] s, er;
    logic        et, em, stable;
    logic [34:0] hist[$];
    ph = P_IDLE; k = 0; ea = '0; eb = '0; ee = '0; ec = '0;
    er = '0; et = 1'b0; em = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        chk("rst_alu_b", 64'(alu_b), 64'd0);
        chk("rst_alu_cmd", 64'(alu_cmd), 64'd0);
        chk("rst_rsp_result", 64'(rsp_result), 64'd0);
        chk("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
        chk("rst_rsp_mismatch", 64'(rsp_mismatch), 64'd0);
        ph = P_IDLE; ea = '0; eb = '0; ec = '0;
        hist.delete();
      end else begin
        chk("req_ready", 64'(req_ready), 64'(ph == P_IDLE));
        chk("rsp_valid", 64'(rsp_valid), 64'(ph == P_RESP));
        chk("alu_a", 64'(alu_a), 64'(ea));
        chk("alu_b", 64'(alu_b), 64'(eb));
        chk("alu_cmd", 64'(alu_cmd), 64'(ec));
        if (ph == P_RESP) begin
          chk("rsp_result", 64'(rsp_result), 64'(er[34:3]));
          chk("rsp_carryout", 64'(rsp_carryout), 64'(er[2]));
          chk("rsp_zero", 64'(rsp_zero), 64'(er[1]));
          chk("rsp_overflow", 64'(rsp_overflow), 64'(er[0]));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(et));
          chk("rsp_mismatch", 64'(rsp_mismatch), 64'(em));
        end
        case (ph)
          P_IDLE: if (req_valid) begin
            ph = P_SETTLE; k = 0;
            ea = req_a; eb = req_b; ec = req_cmd; ee = req_expect;
            hist.delete();
          end
          P_SETTLE: begin
            k++;
            s = {alu_result, alu_carryout, alu_zero, alu_overflow};
            hist.push_back(s);
            stable = 1'b0;
            if (hist.size() > SETTLE_CYCLES) begin
              stable = 1'b1;
              for (int i = 1; i <= SETTLE_CYCLES; i++)
                if (hist[hist.size() - 1 - i] != s) stable = 1'b0;
            end
            if (stable || k == MAX_WAIT) begin
              ph = P_RESP; er = s; et = !stable;
              em = CHECK_EN && (et || (s[34:3] != ee));
            end
          end
          default: if (rsp_ready) ph = P_IDLE;
        endcase
      end
    end
  end

  task automatic op(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] ex, input int md, input int ready_low, input bit hold,
                    output logic [34:0] r, output logic t, output logic m, output int lat);
    bit got;
    got = 1'b0;
    mode = md; req_cmd = cmd; req_a = a; req_b = b; req_expect = ex;
    req_valid = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk); got = req_ready;
      @(posedge clk); #1;
    end
    chk("accept_seen", 64'(got), 64'd1);
    if (!hold) req_valid = 1'b0;
    rsp_ready = (ready_low == 0);
    lat = 0;
    while (!rsp_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk("rsp_seen", 64'(rsp_valid), 64'd1);
    r = {rsp_result, rsp_carryout, rsp_zero, rsp_overflow};
    t = rsp_timeout;
    m = rsp_mismatch;
    for (int i = 0; i < ready_low; i++) begin
      @(posedge clk); #1;
      chk("rsp_hold_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_hold_busy", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rsp_one_cycle", 64'(rsp_valid), 64'd0);
    chk("idle_after_rsp", 64'(req_ready), 64'd1);
    if (hold) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("b2b_accept", 64'(req_ready), 64'd0);
      for (int i = 0; i < 200 && !rsp_valid; i++) begin
        @(posedge clk); #1;
      end
      chk("b2b_rsp_seen", 64'(rsp_valid), 64'd1);
      @(posedge clk); #1;
    end
  endtask

  initial begin : stim
    logic [34:0] r;
    logic        t, m;
    int          lat;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // SLT 1,1 behind a 2-cycle ALU delay
    op(CMD_SLT, 32'd1, 32'd1, 32'd0, M_DELAY, 0, 1'b0, r, t, m, lat);
    chk("t1_latency", 64'(lat), 64'd5);
    chk("t1_result", 64'(r[34:3]), 64'd0);
    chk("t1_flags", 64'(r[2:0]), 64'b010);
    chk("t1_timeout", 64'(t), 64'd0);
    chk("t1_mismatch", 64'(m), 64'd0);

    // SLT -1,1 with three glitching cycles
    op(CMD_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, M_GLITCH, 0, 1'b0, r, t, m, lat);
    chk("t2_latency", 64'(lat), 64'd8);
    chk("t2_result", 64'(r[34:3]), 64'd1);
    chk("t2_zero", 64'(r[1]), 64'd0);
    chk("t2_timeout", 64'(t), 64'd0);

    // Never-settling ALU
    op(CMD_XOR, 32'h0F0F, 32'h00FF, 32'd0, M_TOGGLE, 0, 1'b0, r, t, m, lat);
    chk("t3_latency", 64'(lat), 64'd64);
    chk("t3_timeout", 64'(t), 64'd1);
    chk("t3_mismatch", 64'(m), 64'(CHECK_EN));
    chk("t3_result_hi", 64'(r[34:4]), 64'h7F8);

    // Signed overflow, consumer stalls, next request held by the source
    op(CMD_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, M_DELAY, 5, 1'b1, r, t, m, lat);
    chk("t4_latency", 64'(lat), 64'd7);
    chk("t4_result", 64'(r[34:3]), 64'h8000_0000);
    chk("t4_flags", 64'(r[2:0]), 64'b001);
    chk("t4_timeout", 64'(t), 64'd0);
    chk("t4_mismatch", 64'(m), 64'd0);

    // Reset in the middle of SETTLE
    mode = M_DELAY; req_cmd = CMD_AND; req_a = 32'hF0; req_b = 32'h3C; req_expect = 32'h30;
    req_valid = 1'b1;
    @(negedge clk);
    chk("t5_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("t5_busy", 64'(req_ready), 64'd0);
    reset = 1'b1;
    #1;
    chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t5_req_ready", 64'(req_ready), 64'd1);
    chk("t5_alu_a", 64'(alu_a), 64'd0);
    chk("t5_alu_b", 64'(alu_b), 64'd0);
    chk("t5_alu_cmd", 64'(alu_cmd), 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    op(CMD_OR, 32'h1200, 32'h0034, 32'h1234, M_DELAY, 0, 1'b0, r, t, m, lat);
    chk("t5_latency", 64'(lat), 64'd7);
    chk("t5_result", 64'(r[34:3]), 64'h1234);
    chk("t5_timeout", 64'(t), 64'd0);

    // SUB with a deliberately wrong expected value
    op(CMD_SUB, 32'd5, 32'd5, 32'd1, M_DELAY, 0, 1'b0, r, t, m, lat);
    chk("t6_result", 64'(r[34:3]), 64'd0);
    chk("t6_zero", 64'(r[1]), 64'd1);
    chk("t6_mismatch", 64'(m), 64'(CHECK_EN));

    // NAND through the glitching ALU
    op(CMD_NAND, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FFFF, M_GLITCH, 0, 1'b0, r, t, m, lat);
    chk("t7_latency", 64'(lat), 64'd8);
    chk("t7_result", 64'(r[34:3]), 64'h00FF_FFFF);
    chk("t7_mismatch", 64'(m), 64'd0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual running required finished");
    $fatal(1, "watchdog expired");
  end

endmodule
